// File: rtl/onehot_decoder_sequencer_pkg.sv
// onehot_decoder_sequencer_pkg: shared state encoding and width helper
package onehot_decoder_sequencer_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_GAP = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/onehot_decoder_sequencer_sync_fifo.sv
// sync_fifo: power-of-two circular queue with occupancy count
module sync_fifo
  import onehot_decoder_sequencer_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        din_i,
  output logic [WIDTH-1:0]        dout_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   level_o
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic wp, rp;
  assign wp = push_i && !full_o;
  assign rp = pop_i && !empty_o;
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign dout_o = mem_q[rd_q];
  assign level_o = level_q;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      if (wp) wr_q <= wr_q + 1'b1;
      if (rp) rd_q <= rd_q + 1'b1;
      level_q <= level_q + {{AW{1'b0}}, wp && !rp} - {{AW{1'b0}}, rp && !wp};
    end
  end
  // storage needs no reset; only entries below level are ever read
  always_ff @(posedge clk) begin
    if (wp) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/onehot_decoder_sequencer.sv
// onehot_decoder_sequencer: queue binary indices and replay them as timed one-hot pulses
module onehot_decoder_sequencer
  import onehot_decoder_sequencer_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int DEPTH = 4,
  parameter int HOLD  = 3,
  parameter int GAP   = 1,
  localparam int OUT_W = 2 ** IN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_idx,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      out,
  output logic                  out_valid,
  output logic                  busy,
  output logic [clog2(DEPTH):0] level
);
  localparam int MX = HOLD > GAP ? HOLD : GAP;
  localparam int CW = clog2(MX) < 1 ? 1 : clog2(MX);
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [OUT_W-1:0] out_q;
  logic out_valid_q;
  logic [IN_W-1:0] head;
  logic full, empty, cnt_done, load;
  sync_fifo #(.WIDTH(IN_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(in_valid && in_ready), .pop_i(load), .din_i(in_idx),
    .dout_o(head), .full_o(full), .empty_o(empty), .level_o(level)
  );
  assign cnt_done = cnt_q == '0;
  // a new pulse starts from idle, at the end of a gap, or back-to-back when there is no gap
  assign load = !empty && (state_q == ST_IDLE ||
                (cnt_done && (state_q == ST_GAP || (state_q == ST_HOLD && GAP == 0))));
  assign in_ready = !full;
  assign out = out_q;
  assign out_valid = out_valid_q;
  assign busy = state_q != ST_IDLE || !empty;
  // sequencer: hold each pattern HOLD cycles, then GAP zero cycles, then next entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      state_q <= ST_HOLD;
      cnt_q <= CW'(HOLD - 1);
      out_q <= OUT_W'(1) << head;
      out_valid_q <= 1'b1;
    end else if (state_q != ST_IDLE && !cnt_done) begin
      cnt_q <= cnt_q - 1'b1;
    end else if (state_q == ST_HOLD) begin
      state_q <= GAP > 0 ? ST_GAP : ST_IDLE;
      cnt_q <= GAP > 0 ? CW'(GAP - 1) : '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
    end else if (state_q == ST_GAP) begin
      state_q <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_onehot_decoder_sequencer.sv
// tb_onehot_decoder_sequencer: directed checks of decode, timing, backpressure, wrap and reset
module tb_onehot_decoder_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [1:0] in_idx = '0;
  logic in_ready, out_valid, busy;
  logic [3:0] out;
  logic [2:0] level;
  logic b_valid = 1'b0;
  logic [1:0] b_idx = '0;
  logic b_ready, b_out_valid, b_busy;
  logic [3:0] b_out;
  logic [2:0] b_level;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onehot_decoder_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .busy(busy), .level(level)
  );

  onehot_decoder_sequencer #(.HOLD(1), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_idx(b_idx), .in_ready(b_ready),
    .out(b_out), .out_valid(b_out_valid), .busy(b_busy), .level(b_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] seq2 [16];
    logic [2:0] lvl3 [8];
    logic [1:0] list4 [6];
    logic pv, hs;
    int pulses, ni, no;
    seq2 = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
             4'h8, 4'h8, 4'h8, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
    lvl3 = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4};
    list4 = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3};

    step();
    step();
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", level, 0);
    rst = 1'b0;
    step();

    // single push of idx 2
    in_valid = 1'b1;
    in_idx = 2'd2;
    step();
    in_valid = 1'b0;
    chk("t1_k_out", out, 0);
    chk("t1_k_level", level, 1);
    chk("t1_k_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_pulse_out", out, 4'b0100);
      chk("t1_pulse_valid", out_valid, 1);
    end
    step();
    chk("t1_gap_out", out, 0);
    chk("t1_gap_valid", out_valid, 0);
    chk("t1_gap_busy", busy, 1);
    step();
    chk("t1_idle_busy", busy, 0);

    // four pushes on consecutive edges, ordering and spacing preserved
    in_valid = 1'b1;
    in_idx = 2'd0;
    step();
    chk("t2_k0_out", out, 0);
    in_idx = 2'd1;
    step();
    chk("t2_seq0", out, seq2[0]);
    in_idx = 2'd3;
    step();
    chk("t2_seq1", out, seq2[1]);
    in_idx = 2'd2;
    step();
    chk("t2_seq2", out, seq2[2]);
    chk("t2_level_peak", level, 3);
    in_valid = 1'b0;
    for (int j = 3; j < 16; j++) begin
      step();
      chk("t2_seq", out, seq2[j]);
    end
    step();
    chk("t2_idle_busy", busy, 0);

    // hold valid for 8 cycles: backpressure when full
    pulses = 0;
    pv = 1'b0;
    in_valid = 1'b1;
    in_idx = 2'd1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid && !pv) begin
        pulses++;
        chk("t3_pulse_val", out, 4'b0010);
      end
      pv = out_valid;
      chk("t3_level", level, lvl3[i]);
      chk("t3_in_ready", in_ready, lvl3[i] != 3'd4);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 200 && busy; i++) begin
      step();
      if (out_valid && !pv) begin
        pulses++;
        chk("t3_pulse_val", out, 4'b0010);
      end
      pv = out_valid;
    end
    chk("t3_drained", busy, 0);
    chk("t3_pulse_count", pulses, 6);

    // more than DEPTH pushes with handshake-driven flow, pointers wrap
    ni = 0;
    no = 0;
    pv = 1'b0;
    for (int c = 0; c < 200 && !(ni == 6 && no == 6 && !busy); c++) begin
      in_valid = ni < 6;
      in_idx = ni < 6 ? list4[ni] : 2'd0;
      hs = in_valid && in_ready;
      step();
      if (hs) ni++;
      if (out_valid && !pv) begin
        chk("t4_order", out, no < 6 ? 4'(4'd1 << list4[no]) : 4'd0);
        no++;
      end
      pv = out_valid;
      chk("t4_level_max", level <= 3'd4, 1);
    end
    in_valid = 1'b0;
    chk("t4_pushed", ni, 6);
    chk("t4_popped", no, 6);

    // reset during second hold cycle with two entries queued
    step();
    in_valid = 1'b1;
    in_idx = 2'd0;
    step();
    in_idx = 2'd1;
    step();
    in_idx = 2'd2;
    step();
    in_valid = 1'b0;
    chk("t5_pre_out", out, 4'b0001);
    chk("t5_pre_level", level, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_out", out, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_level", level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_no_stale", out, 0);
    end

    // HOLD=1 GAP=0 instance: back-to-back pulses
    b_valid = 1'b1;
    b_idx = 2'd0;
    step();
    chk("t6_k_out", b_out, 0);
    b_idx = 2'd1;
    step();
    chk("t6_p0", b_out, 4'b0001);
    b_idx = 2'd2;
    step();
    b_valid = 1'b0;
    chk("t6_p1", b_out, 4'b0010);
    step();
    chk("t6_p2", b_out, 4'b0100);
    chk("t6_p2_valid", b_out_valid, 1);
    step();
    chk("t6_end_out", b_out, 0);
    chk("t6_end_valid", b_out_valid, 0);
    chk("t6_end_busy", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
